// File: rtl/program_loader_pkg.sv
// Shared constants and state encodings for the serial program loader and its UART receiver.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BITS_PER_FRAME = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling timer, LSB-first shifter and stop-bit check.
module uart_rx
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    // [0],[1] form the synchroniser; [2] is the previous synchronised level for edge detection
    logic [2:0]    sync_q;
    logic          rx_s, fall;

    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    ferr_d  = ~rx_s;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Loads big-endian instruction words from a framed UART byte stream into instruction memory,
// holding the CPU in reset while a frame is in flight.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int ADDR_WIDTH    = 16,
    parameter int TIMEOUT_BYTES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    localparam int TMO_LIMIT = TIMEOUT_BYTES * BITS_PER_FRAME * CLKS_PER_BIT;
    localparam int MAX_WORDS = 2 ** (ADDR_WIDTH - 2);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    ld_state_e             state_q, state_d;
    logic [7:0]            chk_q, chk_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           word_q, word_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           words_q, words_d;
    logic [15:0]           len_full;
    logic                  in_frame;

    assign len_full = {len_q[15:8], rx_data};
    assign in_frame = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            chk_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        words_d = words_q;
        tmo_d   = '0;
        if (in_frame && !rx_valid) tmo_d = tmo_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    chk_d   = '0;
                    idx_d   = '0;
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    chk_d       = chk_q ^ rx_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_full;
                    chk_d = chk_q ^ rx_data;
                    if (int'(len_full) > MAX_WORDS) state_d = ST_ERR;
                    else if (len_full == 16'd0)     state_d = ST_CHECK;
                    else                            state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    chk_d  = chk_q ^ rx_data;
                    word_d = {word_q[15:0], rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_WIDTH'({words_q, 2'b00});
                        data_d  = {word_q, rx_data};
                        words_d = words_q + 16'd1;
                        if (words_d == len_q) state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_valid) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                done_d  = 1'b0;
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Line faults and stalled senders abort the frame regardless of where it stands
        if (in_frame && (rx_ferr || tmo_d == 32'(TMO_LIMIT))) state_d = ST_ERR;
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: frames are built with their own checksum and the
// expected memory writes queued, then compared as mem_we pulses appear.
module tb_program_loader;

    localparam int CPB = 4;
    localparam int AW  = 16;
    localparam int TMO = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          cpu_hold, load_done, load_error;
    logic [15:0]   words_loaded;

    program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .TIMEOUT_BYTES(TMO)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;
    int          we_cnt  = 0;
    int          rv_cnt  = 0;
    logic [47:0] sb[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  run_chk;
    int          widx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mem_we) begin
            logic [47:0] e;
            we_cnt++;
            if (sb.size() == 0) begin
                check_val("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_val("we_addr", 32'(mem_addr), 32'(e[47:32]));
                check_val("we_data", mem_data, e[31:0]);
            end
        end
    end

    always @(posedge clock) if (u_dut.rx_valid) rv_cnt++;

    task automatic start_frame(input logic [15:0] len);
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(len[15:8]);
        tx_q.push_back(len[7:0]);
        run_chk = len[15:8] ^ len[7:0];
        widx    = 0;
    endtask

    task automatic add_word(input logic [31:0] w, input bit expect_write);
        for (int k = 3; k >= 0; k--) begin
            tx_q.push_back(w[k*8 +: 8]);
            run_chk = run_chk ^ w[k*8 +: 8];
        end
        if (expect_write) sb.push_back({16'(widx * 4), w});
        widx++;
    endtask

    task automatic finish_frame(input logic [7:0] flip);
        tx_q.push_back(run_chk ^ flip);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic send_all(input bit hold_check);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], 1'b1);
            if (hold_check && i == 3) check_val("hold_mid", 32'(cpu_hold), 32'd1);
        end
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (load_done || load_error) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("end_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int we0;
        int rv0;
        bit seen;

        repeat (3) @(negedge clock);
        check_val("rst_we",    32'(mem_we),       32'd0);
        check_val("rst_hold",  32'(cpu_hold),     32'd0);
        check_val("rst_done",  32'(load_done),    32'd0);
        check_val("rst_err",   32'(load_error),   32'd0);
        check_val("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Two-word frame with a correct checksum
        start_frame(16'd2);
        add_word(32'hDEADBEEF, 1'b1);
        add_word(32'h00000001, 1'b1);
        finish_frame(8'h00);
        we0 = we_cnt;
        send_all(1'b1);
        wait_end();
        check_val("t1_done",  32'(load_done),    32'd1);
        check_val("t1_err",   32'(load_error),   32'd0);
        check_val("t1_words", 32'(words_loaded), 32'd2);
        check_val("t1_hold",  32'(cpu_hold),     32'd0);
        check_val("t1_wes",   32'(we_cnt - we0), 32'd2);
        check_val("t1_sb",    32'(sb.size()),    32'd0);

        // Same frame, corrupted checksum: words still land, then the error flag
        start_frame(16'd2);
        add_word(32'hDEADBEEF, 1'b1);
        add_word(32'h00000001, 1'b1);
        finish_frame(8'h02);
        we0 = we_cnt;
        send_all(1'b1);
        wait_end();
        check_val("t2_err",  32'(load_error),   32'd1);
        check_val("t2_done", 32'(load_done),    32'd0);
        check_val("t2_wes",  32'(we_cnt - we0), 32'd2);
        check_val("t2_sb",   32'(sb.size()),    32'd0);

        // Leading junk, then an empty frame
        tx_q.delete();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        we0 = we_cnt;
        send_all(1'b0);
        wait_end();
        check_val("t3_done",  32'(load_done),    32'd1);
        check_val("t3_err",   32'(load_error),   32'd0);
        check_val("t3_words", 32'(words_loaded), 32'd0);
        check_val("t3_wes",   32'(we_cnt - we0), 32'd0);

        // Sender stalls mid-word
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        we0 = we_cnt;
        send_all(1'b1);
        wait_end();
        check_val("t4_err",  32'(load_error),   32'd1);
        check_val("t4_done", 32'(load_done),    32'd0);
        check_val("t4_hold", 32'(cpu_hold),     32'd0);
        check_val("t4_wes",  32'(we_cnt - we0), 32'd0);

        // Bad stop bit inside DATA, then a short glitch on the idle line
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h12);
        send_all(1'b1);
        send_byte(8'h56, 1'b0);
        wait_end();
        check_val("t5_err",  32'(load_error), 32'd1);
        check_val("t5_hold", 32'(cpu_hold),   32'd0);
        rv0 = rv_cnt;
        @(negedge clock);
        rx = 1'b0;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        check_val("t5_glitch", 32'(rv_cnt - rv0), 32'd0);
        check_val("t5_err2",   32'(load_error),   32'd1);

        // Reset while a write strobe is high in the middle of a frame
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h23);
        tx_q.push_back(8'h45);
        tx_q.push_back(8'h67);
        sb.push_back({16'h0000, 32'h01234567});
        send_all(1'b1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("t6_we_seen", 32'(seen), 32'd1);
        check_val("t6_hold_pre", 32'(cpu_hold), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("t6_rst_we",    32'(mem_we),       32'd0);
        check_val("t6_rst_hold",  32'(cpu_hold),     32'd0);
        check_val("t6_rst_done",  32'(load_done),    32'd0);
        check_val("t6_rst_err",   32'(load_error),   32'd0);
        check_val("t6_rst_words", 32'(words_loaded), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        start_frame(16'd1);
        add_word(32'hCAFEBABE, 1'b1);
        finish_frame(8'h00);
        we0 = we_cnt;
        send_all(1'b1);
        wait_end();
        check_val("t6_done",  32'(load_done),    32'd1);
        check_val("t6_words", 32'(words_loaded), 32'd1);
        check_val("t6_wes",   32'(we_cnt - we0), 32'd1);
        check_val("t6_sb",    32'(sb.size()),    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
